microstore_seq: RTL



---
 rtl/microstore_seq_if.sv | 12 +
 rtl/microstore_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/microstore_seq_if.sv
// rtl/microstore_seq_if.sv - control-store write port shared by microstore_seq and its loader
interface microstore_seq_if #(
  parameter int IDX_W  = 7,
  parameter int WORD_W = 45
);
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/microstore_seq.sv
// rtl/microstore_seq.sv - writable microprogrammed sequencer with RAM control store
// MSEQ_STACK_EN builds the CALL/RET return stack; otherwise CALL=JMP, RET=INC.
module microstore_seq #(
  parameter int    IDX_W      = 7,
  parameter int    WORD_W     = 45,
  parameter int    RESET_ADDR = 0,
  parameter int    STK_DEPTH  = 4,
  parameter string INIT_FILE  = "microstore.hex"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic [IDX_W-1:0]        opcode,
  input  logic [3:0]              cond,
  microstore_seq_if.slave         wr,
  output logic [WORD_W-IDX_W-6:0] ctrl,
  output logic [IDX_W-1:0]        upc,
  output logic                    valid,
  output logic                    stk_err
);
  localparam logic [IDX_W-1:0] RST_A = IDX_W'(RESET_ADDR);
  localparam logic [2:0] OP_INC = 3'd0, OP_JMP = 3'd1, OP_BRT = 3'd2, OP_BRF = 3'd3;
  localparam logic [2:0] OP_DISP = 3'd4, OP_CALL = 3'd5, OP_RET = 3'd6, OP_WAIT = 3'd7;

  if (WORD_W < IDX_W + 6 || STK_DEPTH < 1 || STK_DEPTH > 8) begin : g_bad_cfg
    $error("microstore_seq: unsupported parameters for image %s", INIT_FILE);
  end

  typedef enum logic {FETCH0, RUN} state_t;

  // Contents persist across reset; the store is filled through the write port.
  logic [WORD_W-1:0] mem [2**IDX_W];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  upc_q, upc_d;
  logic [WORD_W-1:0] cur_q, cur_d;
  logic              valid_q, valid_d;

  logic [IDX_W-1:0]  na, upc_inc, nxt;
  logic [2:0]        op;
  logic              c_sel, advance;

  assign na      = cur_q[IDX_W-1:0];
  assign op      = cur_q[IDX_W+4:IDX_W+2];
  assign c_sel   = cond[cur_q[IDX_W+1:IDX_W]];
  assign upc_inc = upc_q + IDX_W'(1);

`ifdef MSEQ_STACK_EN
  localparam int SP_W = $clog2(STK_DEPTH + 1);
  localparam int PW   = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STK_DEPTH);

  logic [IDX_W-1:0] stk_q [2**PW];
  logic [IDX_W-1:0] stk_d [2**PW];
  logic [SP_W-1:0]  sp_q, sp_d, sp_dec;
  logic             err_q, err_d;
  logic             step;

  assign step   = !stall && (state_q == RUN);
  assign sp_dec = sp_q - SP_W'(1);
`endif

  always_comb begin
    nxt     = upc_inc;
    advance = 1'b1;
`ifdef MSEQ_STACK_EN
    stk_d = stk_q;
    sp_d  = sp_q;
    err_d = err_q;
`endif
    case (op)
      OP_INC:  nxt = upc_inc;
      OP_JMP:  nxt = na;
      OP_BRT:  nxt = c_sel ? na : upc_inc;
      OP_BRF:  nxt = c_sel ? upc_inc : na;
      OP_DISP: nxt = opcode;
      OP_CALL: begin
        nxt = na;
`ifdef MSEQ_STACK_EN
        // A full stack drops the push but still takes the jump.
        if (step) begin
          if (sp_q == SP_FULL) begin
            err_d = 1'b1;
          end else begin
            stk_d[sp_q[PW-1:0]] = upc_inc;
            sp_d                = sp_q + SP_W'(1);
          end
        end
`endif
      end
      OP_RET: begin
`ifdef MSEQ_STACK_EN
        if (sp_q == '0) begin
          nxt = RST_A;
          if (step) err_d = 1'b1;
        end else begin
          nxt = stk_q[sp_dec[PW-1:0]];
          if (step) sp_d = sp_dec;
        end
`else
        nxt = upc_inc;
`endif
      end
      OP_WAIT: advance = c_sel;
    endcase
  end

  // Fetch reads the store combinationally into cur, so a same-edge write is not seen.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    cur_d   = cur_q;
    valid_d = valid_q;
    if (!stall) begin
      if (state_q == FETCH0) begin
        cur_d   = mem[RST_A];
        valid_d = 1'b1;
        state_d = RUN;
      end else if (advance) begin
        upc_d = nxt;
        cur_d = mem[nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH0;
      upc_q   <= RST_A;
      cur_q   <= '0;
      valid_q <= 1'b0;
`ifdef MSEQ_STACK_EN
      stk_q   <= '{default: '0};
      sp_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
`ifdef MSEQ_STACK_EN
      stk_q   <= stk_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr.wr_en) mem[wr.wr_addr] <= wr.wr_data;
  end

  assign ctrl  = cur_q[WORD_W-1:IDX_W+5];
  assign upc   = upc_q;
  assign valid = valid_q;
`ifdef MSEQ_STACK_EN
  assign stk_err = err_q;
`else
  assign stk_err = 1'b0;
`endif
endmodule
